uart_tx_engine: RTL
===================

Name: uart_tx_engine

Overview:
Parametrised, runtime-configurable UART transmitter with input buffering. It accepts data words over a valid/ready handshake into an internal FIFO and serialises them LSB-first on a single line. Each frame is a start bit, 5–8 data bits, an optional even/odd parity bit and 1 or 2 stop bits. It generates its own baud/oversampling tick from the system clock and is the RTL DUT counterpart that the UART agents drive and monitor.

Parameters:
DATA_WIDTH, 8, width of s_data and FIFO entries; the frame uses the low cfgDataBits bits.
FIFO_DEPTH, 8, FIFO entries; must be a power of 2 and ≥2.
DIV_WIDTH, 16, width of cfgBaudDiv.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
s_valid  input  1  write request
s_data  input  DATA_WIDTH  word to transmit
s_ready  output  1  FIFO can accept; equals !full
cfgDataBits  input  4  DATA_TYPE_E: 5..8; values <5 treated as 5, >8 treated as 8
cfgParityEnable  input  1  1 = insert parity bit
cfgParityType  input  1  PARITY_TYPE_E: 0 even, 1 odd
cfgStopBits  input  2  STOP_BIT_E: 1 or 2; 0 or 3 treated as 1
cfgOverSampling  input  5  OVER_SAMPLING_E: 16 or 13; any other value treated as 16
cfgBaudDiv  input  DIV_WIDTH  clocks per oversample tick; 0 treated as 1
tx  output  1  serial line, idle high
busy  output  1  FSM not IDLE
frameDone  output  1  one-cycle pulse on completion of the last stop bit
fifoLevel  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- All outputs are registered. Reset values: tx=1, busy=0, frameDone=0, fifoLevel=0, s_ready=1. The FIFO is emptied and the FSM goes to IDLE.
- Reset mid-frame aborts the frame. tx returns to 1 at the reset edge, and the partial frame is not resumed.
- Push occurs when s_valid && s_ready. While full, s_ready=0 and s_data is ignored.
- A push and a pop in the same cycle leave fifoLevel unchanged.
- Bit period = effDiv × effOversampling clocks.
- A tick counter runs 0..effDiv-1. An oversample counter advances on each tick; the bit ends when it reaches effOversampling-1 on a tick.
- Both counters clear at every frame start, so the first bit period starts exactly at the start edge.
- Configuration is latched at the pop edge. Config changes mid-frame affect only the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START at any edge where the FIFO is non-empty. The FIFO is popped at that edge, and tx<=0 and busy<=1 from the same edge.
- A word pushed into an empty FIFO while IDLE therefore drives tx low one cycle after its push edge.
- START → DATA after one bit period. tx carries data[bitIdx], with bitIdx 0..dataBits-1, LSB first.
- DATA → PARITY (if enabled) or STOP after dataBits bit periods.
- Parity bit: even = XOR of the used data bits; odd = its inverse. Bits above dataBits-1 are excluded.
- STOP drives tx=1 for stopBits bit periods.
- At the end of STOP, frameDone pulses for one cycle.
  - If the FIFO is non-empty at that edge, the FSM pops and enters START directly, with no idle gap.
  - Otherwise it enters IDLE and busy<=0.
- Frame length in clocks = bitPeriod × (1 + dataBits + parityEnable + stopBits).

Decomposition:
- UartGlobalPkg gains:
  - UART_TX_STATE_E (IDLE, START, DATA, PARITY, STOP);
  - function uartParity(data, dataBits, parityType);
  - a UartTxCfgStruct that bundles the latched configuration, reusing DATA_TYPE_E, PARITY_TYPE_E, STOP_BIT_E and OVER_SAMPLING_E.
- One sub-module: uart_tx_fifo. It is a synchronous FIFO with parameters DATA_WIDTH and FIFO_DEPTH, full/empty flags, a level output, and pointers one bit wider than the address for wrap-around.

Test Plan:
1. Set cfgBaudDiv=2, OS16, 8 bits, even parity, 1 stop; push 0xA5.
   -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 32 clocks; total 352 clocks; frameDone pulses once; busy then falls.
2. Set 7 bits, odd parity, 2 stop, cfgBaudDiv=1, OS16; push 0x41.
   -> data bits 1,0,0,0,0,0,1, parity 1, stop held 32 clocks; bit 7 of s_data is ignored.
3. Set OS13, cfgBaudDiv=1, 5 bits, no parity, 2 stop; push 0x1F then 0x00 back-to-back.
   -> each frame is 104 clocks; the second start bit begins on the edge the first stop ends, with no gap; frameDone pulses twice.
4. FIFO_DEPTH=4, one push per cycle of 6 words while idle.
   -> the first word pops immediately; s_ready drops after the 5th accept; the 6th word stalls until the first frame completes; fifoLevel peaks at 4.
5. Assert reset for 1 cycle at clock 100 of a frame with 3 words queued.
   -> tx=1, busy=0, fifoLevel=0 the next cycle; no further frames are sent.
6. Change cfgDataBits from 8 to 6 mid-frame.
   -> the current frame completes with 8 data bits; the next frame uses 6.

Source files
------------

// File: rtl/uart_tx_engine_pkg.sv
// Shared types and helpers for the UART transmit engine.
package uart_tx_engine_pkg;

  localparam int unsigned DATA_BITS_MAX = 8;

  typedef enum logic [3:0] {
    DATA_5 = 4'd5,
    DATA_6 = 4'd6,
    DATA_7 = 4'd7,
    DATA_8 = 4'd8
  } data_type_e;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_type_e;

  typedef enum logic [1:0] {
    STOP_1 = 2'd1,
    STOP_2 = 2'd2
  } stop_bit_e;

  typedef enum logic [4:0] {
    OS_13 = 5'd13,
    OS_16 = 5'd16
  } over_sampling_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  // Frame configuration captured when a word leaves the FIFO.
  typedef struct packed {
    data_type_e     data_bits;
    logic           parity_en;
    parity_type_e   parity_type;
    stop_bit_e      stop_bits;
    over_sampling_e over_sampling;
  } uart_tx_cfg_t;

  localparam uart_tx_cfg_t CFG_RESET = '{
    data_bits:     DATA_8,
    parity_en:     1'b0,
    parity_type:   PARITY_EVEN,
    stop_bits:     STOP_1,
    over_sampling: OS_16
  };

  // Out-of-range data widths clamp to the nearest legal width.
  function automatic data_type_e norm_data_bits(input logic [3:0] raw);
    if (raw < 4'd5) return DATA_5;
    if (raw > 4'd8) return DATA_8;
    return data_type_e'(raw);
  endfunction

  function automatic stop_bit_e norm_stop_bits(input logic [1:0] raw);
    return (raw == 2'd2) ? STOP_2 : STOP_1;
  endfunction

  function automatic over_sampling_e norm_over_sampling(input logic [4:0] raw);
    return (raw == 5'd13) ? OS_13 : OS_16;
  endfunction

  // Parity over the used data bits only; odd parity is the inverse of even.
  function automatic logic uart_parity(input logic [DATA_BITS_MAX-1:0] data,
                                       input data_type_e data_bits,
                                       input parity_type_e parity_type);
    logic p;
    p = 1'b0;
    for (int i = 0; i < int'(DATA_BITS_MAX); i++) begin
      if (i < int'(data_bits)) p = p ^ data[i];
    end
    return p ^ (parity_type == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Valid/ready write port into the transmit FIFO.
interface uart_tx_engine_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered flags and occupancy; pointers carry a wrap bit.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]         wr_ptr_d, rd_ptr_d, level_d;
  logic                  push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and the occupancy they imply.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    level_d = wr_ptr_d - rd_ptr_d;
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level    <= level_d;
      full     <= (level_d == PW'(FIFO_DEPTH));
      empty    <= (level_d == PW'(0));
    end
  end

  // Storage array; contents need no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered UART transmitter: FIFO front end, baud/oversample timing and frame FSM.
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_engine_if.slave             bus,
  input  logic [3:0]                  cfgDataBits,
  input  logic                        cfgParityEnable,
  input  logic                        cfgParityType,
  input  logic [1:0]                  cfgStopBits,
  input  logic [4:0]                  cfgOverSampling,
  input  logic [DIV_WIDTH-1:0]        cfgBaudDiv,
  output logic                        tx,
  output logic                        busy,
  output logic                        frameDone,
  output logic [$clog2(FIFO_DEPTH):0] fifoLevel
);

  uart_tx_state_e        state_q, state_d;
  uart_tx_cfg_t          cfg_q, cfg_d, new_cfg_c;
  logic [DIV_WIDTH-1:0]  div_q, div_d, new_div_c;
  logic [DIV_WIDTH-1:0]  tick_cnt_q, tick_cnt_d;
  logic [4:0]            os_cnt_q, os_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_d, busy_d, done_d;

  logic                  fifo_full, fifo_empty, fifo_pop_c;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  tick_c, bit_end_c, data_last_c, stop_last_c, frame_end_c;

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (bus.s_valid),
    .wr_data (bus.s_data),
    .pop     (fifo_pop_c),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifoLevel)
  );

  assign bus.s_ready = !fifo_full;

  // Sanitised configuration offered to the next frame.
  always_comb begin
    new_cfg_c.data_bits     = norm_data_bits(cfgDataBits);
    new_cfg_c.parity_en     = cfgParityEnable;
    new_cfg_c.parity_type   = parity_type_e'(cfgParityType);
    new_cfg_c.stop_bits     = norm_stop_bits(cfgStopBits);
    new_cfg_c.over_sampling = norm_over_sampling(cfgOverSampling);
  end

  assign new_div_c   = (cfgBaudDiv == '0) ? DIV_WIDTH'(1) : cfgBaudDiv;
  assign tick_c      = (tick_cnt_q == div_q - DIV_WIDTH'(1));
  assign bit_end_c   = tick_c && (os_cnt_q == 5'(cfg_q.over_sampling) - 5'd1);
  assign data_last_c = (bit_idx_q == 4'(cfg_q.data_bits) - 4'd1);
  assign stop_last_c = (stop_cnt_q == (cfg_q.stop_bits == STOP_2));
  assign frame_end_c = (state_q == STOP) && bit_end_c && stop_last_c;
  assign fifo_pop_c  = !fifo_empty && ((state_q == IDLE) || frame_end_c);

  // Next-state, timing counters and line level.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    os_cnt_d   = os_cnt_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx;
    busy_d     = busy;
    done_d     = 1'b0;

    if (state_q != IDLE) begin
      if (tick_c) begin
        tick_cnt_d = '0;
        os_cnt_d   = bit_end_c ? 5'd0 : os_cnt_q + 5'd1;
      end else begin
        tick_cnt_d = tick_cnt_q + DIV_WIDTH'(1);
      end
    end

    case (state_q)
      IDLE: ;
      START: begin
        if (bit_end_c) begin
          state_d   = DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = 4'd0;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (!data_last_c) begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 4'd1;
          end else if (cfg_q.parity_en) begin
            state_d = PARITY;
            tx_d    = parity_q;
          end else begin
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end_c) begin
          if (stop_last_c) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop starts a frame, overriding the end-of-frame return to IDLE.
    if (fifo_pop_c) begin
      state_d    = START;
      cfg_d      = new_cfg_c;
      div_d      = new_div_c;
      tick_cnt_d = '0;
      os_cnt_d   = 5'd0;
      shreg_d    = fifo_rd_data;
      bit_idx_d  = 4'd0;
      stop_cnt_d = 1'b0;
      parity_d   = uart_parity(8'(fifo_rd_data), new_cfg_c.data_bits, new_cfg_c.parity_type);
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cfg_q      <= CFG_RESET;
      div_q      <= DIV_WIDTH'(1);
      tick_cnt_q <= '0;
      os_cnt_q   <= 5'd0;
      shreg_q    <= '0;
      bit_idx_q  <= 4'd0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx         <= tx_d;
      busy       <= busy_d;
      frameDone  <= done_d;
    end
  end

endmodule
